bcd_convert_ctrl: RTL
=====================

# bcd_convert_ctrl

Multi-cycle binary-to-BCD conversion engine shared between two requesters (CPU result path and display register path). It accepts one binary value at a time through a round-robin arbiter and converts it with iterative shift-add-3 (double dabble), one bit per cycle. It returns seven BCD digit lanes in the CPU's 112-bit display-bus format with a valid/ready output handshake. It replaces per-requester combinational divide/modulo converters with one sequenced datapath.

## Interface
- BIN_W, 24: binary input width; one shift cycle per bit.
- DIGITS, 7: number of BCD digit lanes; output width is DIGITS*16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has a value to convert.
- req0_bin / req1_bin  in  BIN_W  binary value, unsigned.
- req0_ready / req1_ready  out  1  grant; a transfer occurs when valid and ready are both high at a clock edge.
- out_valid  out  1  conversion result available.
- out_ready  in  1  consumer accepts the result.
- out_bcd  out  DIGITS*16  lane i = out_bcd[16i+15:16i], digit in bits [3:0], bits [15:4] = 0; lane 0 is the ones digit.
- out_src  out  1  index of the requester that supplied the value.
- out_ovf  out  1  input exceeded 10^DIGITS-1.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: reqN_ready is driven combinationally to 1 only for the requester selected by the arbiter, and only in IDLE.
  - Only one requester valid: that requester is granted.
  - Both requesters valid: grant the one not granted last.
  - Reset value of the last-grant pointer is 1, so req0 wins the first tie.
- On accept, the block captures bin, src and ovf (bin > 10^DIGITS-1, compared against a package constant), clears the digit registers, loads shift count BIN_W, and moves to SHIFT.
- SHIFT, each cycle:
  - Every 4-bit digit >= 5 gets +3.
  - The {digits, bin} register then shifts left by 1, MSB of bin first.
  - Count decrements; at count 1 the state moves to DONE.
- DONE: out_valid = 1.
  - out_bcd is presented from the digit registers, or all lanes = 9 when ovf = 1.
  - Outputs hold stable until out_valid && out_ready, then the state returns to IDLE and out_valid drops.
- No requester is granted in SHIFT or DONE. Requester valid/bin may change freely when not granted.
- Arithmetic: the digit register is DIGITS*4 bits. When ovf = 0 the shifted-out digit MSBs are always 0; when ovf = 1 the digit value is discarded.
- Reset (any state, any cycle) values:
  - state = IDLE
  - out_valid = 0
  - out_bcd = 0
  - out_src = 0
  - out_ovf = 0
  - count = 0
  - last-grant pointer = 1
  - An in-flight conversion is discarded and not resumed.

## Timing
- Accept edge E0 → SHIFT for edges E0+1 … E0+BIN_W → out_valid = 1 in the cycle after edge E0+BIN_W (latency BIN_W+1 cycles, 25 by default).
- Result handshake edge → IDLE. Earliest next accept is the following edge, so minimum spacing is BIN_W+2 cycles.
- out_ready high on the first DONE cycle causes a one-cycle out_valid pulse.
- reqN_ready depends combinationally on reqN_valid and the state; the outputs have no combinational path from out_ready.

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - defaults BIN_W=24, DIGITS=7, LANE_W=16;
  - the max-value constant 10^DIGITS-1;
  - an all-nines lane pattern.
- Sub-module bcd_dabble_step: combinational, parameterised by DIGITS. It takes {digits, bin} and returns the add-3-then-shift result, and is instantiated once.
- Arbiter, counter and FSM live in bcd_convert_ctrl.

## Test plan
- req0_bin=1234567, req1 idle → out_bcd lanes 0..6 = 7,6,5,4,3,2,1; out_src=0; out_ovf=0; out_valid rises exactly 25 cycles after the accept edge.
- req1_bin=0 → all lanes 0, out_src=1. req1_bin=9999999 → all lanes 9, out_ovf=0.
- req0_bin=10000000, then 16777215 → out_ovf=1, all lanes 9, for both values.
- Both requesters held valid from reset release with out_ready=1 → grants go req0, req1, req0, req1 on successive conversions; out_src follows the same sequence.
- Result ready, out_ready held low for 10 cycles → out_bcd/out_src/out_valid stable; req0_ready and req1_ready stay 0 throughout; accept occurs on the edge after the result handshake.
- rst_n pulsed low during the 12th SHIFT cycle → out_valid=0 and out_bcd=0 immediately; req0_ready=1 in the first cycle after release when req0_valid=1; the next conversion is correct.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD conversion engine.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned BIN_W_DEF  = 24;
  localparam int unsigned DIGITS_DEF = 7;
  localparam int unsigned LANE_W     = 16;

  // Largest value representable in the given number of decimal digits (10^digits - 1).
  function automatic logic [63:0] max_value(input int unsigned digits);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value(DIGITS_DEF);

  // Lane pattern presented on every lane when the input does not fit.
  localparam logic [LANE_W-1:0] NINES_LANE = 16'h0009;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift {digits, bin} left by one.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter int unsigned BIN_W  = BIN_W_DEF
) (
  input  logic [DIGITS*4+BIN_W-1:0] sr_in,
  output logic [DIGITS*4+BIN_W-1:0] sr_out
);

  localparam int unsigned SR_W = DIGITS * 4 + BIN_W;

  logic [SR_W-1:0] adj;

  // Correct each digit before the shift so it carries correctly into the next decade.
  always_comb begin
    adj = sr_in;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (adj[BIN_W+4*i +: 4] >= 4'd5) begin
        adj[BIN_W+4*i +: 4] = adj[BIN_W+4*i +: 4] + 4'd3;
      end
    end
    sr_out = {adj[SR_W-2:0], 1'b0};
  end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Two-requester binary-to-BCD converter: round-robin arbiter, bit-serial double dabble,
// valid/ready result port in the 16-bit-per-lane display-bus format.
module bcd_convert_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic [BIN_W-1:0]           req0_bin,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [BIN_W-1:0]           req1_bin,
  output logic                       req1_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIGITS*LANE_W-1:0]   out_bcd,
  output logic                       out_src,
  output logic                       out_ovf
);

  localparam int unsigned DIG_W  = DIGITS * 4;
  localparam int unsigned SR_W   = DIG_W + BIN_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
  localparam logic [63:0] MaxVal = max_value(DIGITS);

  state_e                    state_q;
  logic [SR_W-1:0]           sr_q;
  logic [SR_W-1:0]           sr_step;
  logic [CNT_W-1:0]          count_q;
  logic                      last_q;
  logic                      src_q;
  logic                      ovf_q;
  logic                      out_valid_q;
  logic [DIGITS*LANE_W-1:0]  out_bcd_q;
  logic                      out_src_q;
  logic                      out_ovf_q;

  logic                      gnt_sel;
  logic                      accept;
  logic [BIN_W-1:0]          gnt_bin;
  logic                      gnt_ovf;
  logic [DIGITS*LANE_W-1:0]  res_bcd;

  // Round-robin select: on a tie the requester not granted last wins; grants only in idle.
  always_comb begin
    gnt_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_sel = ~last_q;
    end else begin
      gnt_sel = ~req0_valid;
    end
    req0_ready = (state_q == StIdle) && req0_valid && !gnt_sel;
    req1_ready = (state_q == StIdle) && req1_valid && gnt_sel;
    accept     = req0_ready || req1_ready;
    gnt_bin    = gnt_sel ? req1_bin : req0_bin;
    gnt_ovf    = 64'(gnt_bin) > MaxVal;
  end

  bcd_dabble_step #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) u_step (
    .sr_in (sr_q),
    .sr_out(sr_step)
  );

  // Result lanes built from the digits after the final shift, or all nines on overflow.
  always_comb begin
    res_bcd = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (ovf_q) begin
        res_bcd[i*LANE_W +: LANE_W] = NINES_LANE;
      end else begin
        res_bcd[i*LANE_W +: LANE_W] = LANE_W'(sr_step[BIN_W+4*i +: 4]);
      end
    end
  end

  // Control FSM, shift register, counter and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      count_q     <= '0;
      last_q      <= 1'b1;
      src_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_src_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            // Digit field is cleared by the zero extension of the captured value.
            sr_q    <= SR_W'(gnt_bin);
            count_q <= CNT_W'(BIN_W);
            src_q   <= gnt_sel;
            ovf_q   <= gnt_ovf;
            last_q  <= gnt_sel;
            state_q <= StShift;
          end
        end
        StShift: begin
          sr_q    <= sr_step;
          count_q <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            out_bcd_q   <= res_bcd;
            out_src_q   <= src_q;
            out_ovf_q   <= ovf_q;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_src   = out_src_q;
  assign out_ovf   = out_ovf_q;

endmodule
